// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: byte width and FSM state encoding.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered full/empty/level flags.
// Write acceptance depends only on the registered full flag.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  input  logic               rd_en,
  output logic [UART_DW-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [LW-1:0]      level
);

  logic [UART_DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LW-1:0]      r_level;
  logic               r_full;
  logic               r_empty;
  logic               w_wr_ok;
  logic               w_rd_ok;
  logic [LW-1:0]      w_level_nxt;

  assign w_wr_ok = wr_en & ~r_full;
  assign w_rd_ok = rd_en & ~r_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == {LW{1'b0}});
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign level   = r_level;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter through a start/busy handshake.
// Optional sticky overflow flag enabled by defining UART_TX_QUEUE_OVF_EN.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic               clk_50MHZ,
  input  logic               rst_n,
  input  logic [UART_DW-1:0] wr_data,
  input  logic               wr_en,
  output logic               full,
  output logic               empty,
  output logic [LW-1:0]      level,
  output logic [UART_DW-1:0] data_in,
  output logic               tx_start,
  input  logic               tx_busy
`ifdef UART_TX_QUEUE_OVF_EN
  ,
  input  logic               ovf_clr,
  output logic               ovf
`endif
);

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic               w_pop;
  logic [UART_DW-1:0] w_head;
  logic [UART_DW-1:0] r_data_in;
  logic               r_tx_start;

  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk_50MHZ),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START:     w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) w_state_nxt = WAIT_DONE;
        else         w_state_nxt = WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (!tx_busy) w_state_nxt = IDLE;
        else          w_state_nxt = WAIT_DONE;
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  // tx_start is registered from the next state so it is high exactly while in START.
  always_ff @(posedge clk_50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_data_in  <= {UART_DW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= (w_state_nxt == START);
      if (w_pop) r_data_in <= w_head;
      else       r_data_in <= r_data_in;
    end
  end

  assign tx_start = r_tx_start;
  assign data_in  = r_data_in;

`ifdef UART_TX_QUEUE_OVF_EN
  logic r_ovf;
  logic w_drop;

  assign w_drop = wr_en & full;

  // Set has priority over clear so a drop on the clearing edge is never lost.
  always_ff @(posedge clk_50MHZ or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
    else              r_ovf <= r_ovf;
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: writes push expected bytes, a monitor
// checks every tx_start pulse; a simple UART model drives tx_busy.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int BUSY_CYCLES = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          full, empty, tx_start;
  logic [LW-1:0] level;
  logic [7:0]    data_in;
  logic          tx_busy;
  logic          m_busy = 1'b0;
  logic          force_busy = 1'b0;
`ifdef UART_TX_QUEUE_OVF_EN
  logic          ovf_clr = 1'b0;
  logic          ovf;
`endif

  int        n_total = 0;
  int        n_bad = 0;
  int        n_pulse = 0;
  int        cyc = 0;
  int        last_pulse = -1000;
  logic      prev_start = 1'b0;
  logic [7:0] sb[$];

  assign tx_busy = m_busy | force_busy;

  always #10 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk_50MHZ (clk),
    .rst_n     (rst_n),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .data_in   (data_in),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy)
`ifdef UART_TX_QUEUE_OVF_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf       (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART model: busy rises one cycle after a start pulse and lasts BUSY_CYCLES.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) begin
        @(posedge clk); #1;
        m_busy = 1'b1;
        repeat (BUSY_CYCLES) @(posedge clk);
        #1;
        m_busy = 1'b0;
      end
    end
  end

  // Monitor: every start pulse must match the scoreboard head and respect busy.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && tx_start === 1'b1) begin
      n_pulse++;
      check("start_while_busy", tx_busy, 1'b0);
      check("start_one_cycle", prev_start, 1'b0);
      if (!prev_start) check("gap_after_busy_fall", (cyc - last_pulse) >= 102, 1'b1);
      if (sb.size() == 0) begin
        check("unexpected_start", 1'b1, 1'b0);
      end else begin
        check("tx_byte", data_in, sb.pop_front());
      end
      last_pulse = cyc;
    end
    prev_start = tx_start;
  end

  task automatic write(input logic [7:0] d, input bit accept);
    if (accept) sb.push_back(d);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || tx_busy || tx_start) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, n < 5000, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int snap;
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_data_in", data_in, 8'h00);
`ifdef UART_TX_QUEUE_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte latency
    write(8'hA5, 1'b1);
    check("lat_level_after_write", level, 1);
    check("lat_no_start_yet", tx_start, 1'b0);
    @(negedge clk);
    check("lat_start", tx_start, 1'b1);
    check("lat_data_in", data_in, 8'hA5);
    check("lat_level_after_pop", level, 0);
    check("lat_empty_after_pop", empty, 1'b1);
    @(negedge clk);
    check("lat_start_low", tx_start, 1'b0);
    drain("drain_single");
    check("data_in_held", data_in, 8'hA5);

    // Fill to full while transmitter is busy, then drop a 17th byte
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) write(8'(i), 1'b1);
    check("fill_full", full, 1'b1);
    check("fill_level", level, 16);
    check("fill_not_empty", empty, 1'b0);
    write(8'h10, 1'b0);
    check("drop_level", level, 16);
    check("drop_full", full, 1'b1);
`ifdef UART_TX_QUEUE_OVF_EN
    check("drop_ovf", ovf, 1'b1);
`endif

    // Write while full on the same edge as a pop: write rejected
    wr_data = 8'h11;
    wr_en   = 1'b1;
`ifdef UART_TX_QUEUE_OVF_EN
    ovf_clr = 1'b1;
`endif
    force_busy = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
`ifdef UART_TX_QUEUE_OVF_EN
    ovf_clr = 1'b0;
    check("ovf_set_beats_clear", ovf, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 1'b0);
`endif
    check("pop_with_full_write_level", level, DEPTH - 1 - (tx_start ? 0 : 0));
    check("pop_with_full_write_full", full, 1'b0);
    drain("drain_fill");

    // Three bytes, each sent only after busy falls
    write(8'h01, 1'b1);
    write(8'h02, 1'b1);
    write(8'h03, 1'b1);
    drain("drain_three");

    // Reset in WAIT_DONE with five bytes still queued
    for (int i = 0; i < 6; i++) write(8'h40 + 8'(i), 1'b1);
    repeat (20) @(negedge clk);
    check("pre_reset_level", level, 5);
    check("pre_reset_busy", tx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_empty", empty, 1'b1);
    check("async_rst_tx_start", tx_start, 1'b0);
    check("async_rst_data_in", data_in, 8'h00);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap = n_pulse;
    repeat (300) @(negedge clk);
    check("no_pulse_after_reset", n_pulse, snap);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
